pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipelined CPU. Each cycle it generates the enable and flush strobes for the PC and the fetch, decode, execute and memory pipeline latches. Flush has priority over enable inside every latch. It resolves data-memory wait, taken branches/jumps, load-use hazards and instruction-memory miss, and sequences the halt drain. It also keeps two saturating stall/flush counters for performance debug.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory returns a valid instruction this cycle
- dhit  in  1  data memory completes the memory-stage access this cycle
- mem_dREN  in  1  memory-stage instruction is a load
- mem_dWEN  in  1  memory-stage instruction is a store
- mem_branch_taken  in  1  branch/jump resolved taken in memory stage (PC mux already selects target)
- mem_halt  in  1  halt opcode is in memory stage
- ex_dREN  in  1  execute-stage instruction is a load
- ex_rt  in  5  destination register of execute-stage load
- id_rs, id_rt  in  5 each  source registers of decode-stage instruction
- id_uses_rt  in  1  decode-stage instruction reads rt
- pc_en  out  1  PC register load enable
- fetch_en, decode_en, execute_en, memory_en  out  1 each  latch enables
- fetch_flush, decode_flush, execute_flush  out  1 each  latch clears (bubble insert)
- halt  out  1  registered, sticky CPU halted
- stall_cycles  out  32  saturating count of stalled cycles
- flush_events  out  16  saturating count of taken-branch flushes

## Operation
- FSM states: RUN, DWAIT, HALTING, HALTED. Reset state is RUN.
- Priority inside RUN, highest first: data wait, halt, branch, load-use, imiss, normal.
- Data wait: (mem_dREN|mem_dWEN)&!dhit gives freeze. All enables are 0 and all flushes are 0. Next state is DWAIT.
- DWAIT:
  - While dhit=0: freeze, and mem_branch_taken/mem_halt are ignored.
  - On dhit=1: the RUN decision for halt/branch/load-use/imiss/normal is applied that cycle, and next state is the state RUN would choose.
- Halt: mem_halt=1 gives pc_en=0, memory_en=1, all three flushes=1, and next state HALTING.
- HALTING lasts one cycle: memory_en=1, pc_en=0, flushes=1. Next state is HALTED.
- HALTED:
  - halt=1, all enables 0, all flushes 0.
  - Inputs are ignored; only nRST exits.
- Branch: mem_branch_taken=1 gives pc_en=1, all three flushes=1, memory_en=1. ihit is ignored.
- Load-use: ex_dREN & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
  - Gives pc_en=0, fetch_en=0 (hold IF/ID), decode_flush=1, execute_en=1, memory_en=1.
  - A load-use hazard during an imiss still holds IF/ID, not flush.
- Imiss: ihit=0 gives pc_en=0, fetch_flush=1, decode_en=execute_en=memory_en=1.
- Normal: all enables 1, all flushes 0.
- An enable output whose flush is also 1 is don't-care; it is driven 1 for determinism.
- stall_cycles: +1 on every clock edge where pc_en=0, nRST=1 and state!=HALTED. It saturates at 0xFFFFFFFF.
- flush_events: +1 on every clock edge where the branch case fires. It saturates at 0xFFFF.

## Timing
- Enables and flushes are combinational from state and inputs, so they take effect on the same rising edge. This is zero-cycle latency.
- While nRST=0: state=RUN, halt=0, stall_cycles=0, flush_events=0, and all enable/flush outputs are forced to 0.
- halt rises on the edge after HALTING, which is 2 edges after mem_halt is first sampled in RUN.
- Reset mid-DWAIT or mid-HALTING returns the block to RUN with counters cleared. No pending state survives.
- dhit=1 on the first cycle of an access means no DWAIT entry and no stall count from the data wait.
- Branch and load-use in the same cycle: the branch wins, and the load-use bubble is discarded by the flush.
- Counters update on the same edge as the event that generates them.

## Test plan
- Reset, then ihit=1 and no hazards:
  - All enables are 1 and all flushes 0.
  - halt=0 and both counters stay 0 over 10 cycles.
- Load with mem_dREN=1, dhit=0 for 3 cycles, then 1:
  - 3 cycles of full freeze in DWAIT, then RUN.
  - stall_cycles=3.
- ex_dREN=1, ex_rt=5, id_rs=5:
  - pc_en=0, fetch_en=0, decode_flush=1 for one cycle.
  - The same stimulus with ex_rt=0 produces no stall.
- mem_branch_taken=1 with ihit=0:
  - pc_en=1 and all three flushes=1.
  - flush_events=1 and stall_cycles unchanged.
- mem_halt=1:
  - HALTING, then halt=1 two edges later with all outputs 0 after that.
  - Further branches or dhit have no effect.
  - nRST pulse clears halt.
- Force 0xFFFFFFFE stalls or preload via imiss: the counter saturates at 0xFFFFFFFF, and flush_events saturates at 0xFFFF after 65536 branches.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the five-stage CPU.
// Drives PC/latch enables and flushes, sequences halt, counts stalls/flushes.
//
// Ports:
//   CLK, nRST                       clock, async active-low reset
//   ihit, dhit                      instruction / data memory ready
//   mem_dREN, mem_dWEN              memory-stage load / store
//   mem_branch_taken, mem_halt      memory-stage redirect / halt
//   ex_dREN, ex_rt                  execute-stage load and its destination
//   id_rs, id_rt, id_uses_rt        decode-stage source registers
//   pc_en, *_en, *_flush            combinational pipeline controls
//   halt                            registered sticky halt
//   stall_cycles, flush_events      saturating debug counters
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        mem_branch_taken,
    input  logic        mem_halt,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    output logic        pc_en,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        memory_en,
    output logic        fetch_flush,
    output logic        decode_flush,
    output logic        execute_flush,
    output logic        halt,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        HALTING,
        HALTED
    } state_t;

    // Control vector layout:
    // {pc_en, fetch_en, decode_en, execute_en, memory_en,
    //  fetch_flush, decode_flush, execute_flush}
    // Enables whose flush is set are driven 1 for determinism.
    localparam logic [7:0] CTL_FREEZE = 8'b00000_000;
    localparam logic [7:0] CTL_NORMAL = 8'b11111_000;
    localparam logic [7:0] CTL_BRANCH = 8'b11111_111;
    localparam logic [7:0] CTL_HALT   = 8'b01111_111;
    localparam logic [7:0] CTL_LDUSE  = 8'b00111_010;
    localparam logic [7:0] CTL_IMISS  = 8'b01111_100;

    state_t      state_q, state_d;
    logic        halt_q;
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    logic [7:0]  ctl;
    logic        br_fire;
    logic        dwait;
    logic        ld_use;
    logic        rs_match;
    logic        rt_match;
    logic        stall_inc;

    assign dwait    = (mem_dREN | mem_dWEN) & ~dhit;
    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_uses_rt & (ex_rt == id_rt);
    assign ld_use   = ex_dREN & (ex_rt != 5'd0) & (rs_match | rt_match);

    always_comb begin
        state_d = state_q;
        ctl     = CTL_FREEZE;
        br_fire = 1'b0;
        unique case (state_q)
            RUN, DWAIT: begin
                // In DWAIT only dhit releases the freeze; redirects wait.
                if ((state_q == DWAIT) ? ~dhit : dwait) begin
                    ctl     = CTL_FREEZE;
                    state_d = DWAIT;
                end else begin
                    state_d = RUN;
                    if (mem_halt) begin
                        ctl     = CTL_HALT;
                        state_d = HALTING;
                    end else if (mem_branch_taken) begin
                        ctl     = CTL_BRANCH;
                        br_fire = 1'b1;
                    end else if (ld_use) begin
                        ctl = CTL_LDUSE;
                    end else if (~ihit) begin
                        ctl = CTL_IMISS;
                    end else begin
                        ctl = CTL_NORMAL;
                    end
                end
            end
            HALTING: begin
                ctl     = CTL_HALT;
                state_d = HALTED;
            end
            HALTED: begin
                ctl     = CTL_FREEZE;
                state_d = HALTED;
            end
            default: begin
                ctl     = CTL_FREEZE;
                state_d = RUN;
            end
        endcase
    end

    // Reset overrides every control strobe.
    assign pc_en         = ctl[7] & nRST;
    assign fetch_en      = ctl[6] & nRST;
    assign decode_en     = ctl[5] & nRST;
    assign execute_en    = ctl[4] & nRST;
    assign memory_en     = ctl[3] & nRST;
    assign fetch_flush   = ctl[2] & nRST;
    assign decode_flush  = ctl[1] & nRST;
    assign execute_flush = ctl[0] & nRST;

    assign stall_inc = ~ctl[7] & (state_q != HALTED);

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        if (br_fire && (flush_q != 16'hFFFF)) begin
            flush_d = flush_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
            stall_q <= 32'd0;
            flush_q <= 16'd0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d == HALTED);
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halt         = halt_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl.
// Expected control vectors are queued on drive and popped on sample.
module tb_pipeline_ctrl;

    typedef struct packed {
        logic       ih;
        logic       dh;
        logic       mr;
        logic       mw;
        logic       br;
        logic       mh;
        logic       er;
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
    } stim_t;

    localparam logic [7:0] FRZ  = 8'b00000_000;
    localparam logic [7:0] NORM = 8'b11111_000;
    localparam logic [7:0] BRN  = 8'b11111_111;
    localparam logic [7:0] HLT  = 8'b01111_111;
    localparam logic [7:0] LU   = 8'b00111_010;
    localparam logic [7:0] IMS  = 8'b01111_100;

    logic        CLK;
    logic        nRST;
    logic        ihit, dhit, mem_dREN, mem_dWEN;
    logic        mem_branch_taken, mem_halt, ex_dREN;
    logic [4:0]  ex_rt, id_rs, id_rt;
    logic        id_uses_rt;
    logic        pc_en, fetch_en, decode_en, execute_en, memory_en;
    logic        fetch_flush, decode_flush, execute_flush, halt;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;

    int          checks;
    int          failures;
    logic [8:0]  exp_q[$];
    logic [31:0] stall_m;
    logic [15:0] flush_m;

    pipeline_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt),
        .ex_dREN(ex_dREN), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .pc_en(pc_en), .fetch_en(fetch_en),
        .decode_en(decode_en), .execute_en(execute_en),
        .memory_en(memory_en), .fetch_flush(fetch_flush),
        .decode_flush(decode_flush), .execute_flush(execute_flush),
        .halt(halt), .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic stim_t mk(
        input logic ih, input logic dh, input logic mr, input logic mw,
        input logic br, input logic mh, input logic er,
        input logic [4:0] ert, input logic [4:0] rs,
        input logic [4:0] rt, input logic ur);
        stim_t s;
        s = {ih, dh, mr, mw, br, mh, er, ert, rs, rt, ur};
        return s;
    endfunction

    function automatic logic [8:0] observed();
        return {halt, pc_en, fetch_en, decode_en, execute_en, memory_en,
                fetch_flush, decode_flush, execute_flush};
    endfunction

    // Drive one cycle of inputs, queue the expectation, advance the model.
    task automatic apply(input stim_t s, input logic [8:0] e);
        ihit             = s.ih;
        dhit             = s.dh;
        mem_dREN         = s.mr;
        mem_dWEN         = s.mw;
        mem_branch_taken = s.br;
        mem_halt         = s.mh;
        ex_dREN          = s.er;
        ex_rt            = s.ert;
        id_rs            = s.rs;
        id_rt            = s.rt;
        id_uses_rt       = s.ur;
        exp_q.push_back(e);
        if (!e[8] && !e[7] && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
        if (e[7:0] == BRN && flush_m != 16'hFFFF) flush_m = flush_m + 1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        apply(mk(1,0,0,0,0,0,0,0,0,0,0), 9'd0);
        void'(exp_q.pop_front());
        #3;
        nRST = 1'b1;
        stall_m = 32'd0;
        flush_m = 16'd0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [8:0] e;
        @(negedge CLK);
        ihit = 1; dhit = 0; mem_dREN = 1; mem_dWEN = 0;
        mem_branch_taken = 1; mem_halt = 1; ex_dREN = 1;
        ex_rt = 5; id_rs = 5; id_rt = 0; id_uses_rt = 0;
        exp_q.push_back(9'd0);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", observed(), e);
        end
        checks++;
        if (stall_cycles !== 32'd0 || flush_events !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters got=%h/%h exp=0/0",
                     stall_cycles, flush_events);
        end
        @(negedge CLK);
        do_reset();
    endtask

    task automatic test_normal();
        logic [8:0] e;
        for (int i = 0; i < 10; i++) begin
            apply(mk(1,0,0,0,0,0,0,0,0,0,0), {1'b0, NORM});
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL normal row%0d got=%b exp=%b", i, observed(), e);
            end
            @(negedge CLK);
        end
        checks++;
        if (stall_cycles !== 32'd0 || flush_events !== 16'd0) begin
            failures++;
            $display("FAIL normal_counters got=%h/%h exp=0/0",
                     stall_cycles, flush_events);
        end
    endtask

    task automatic run_rows(input string name, input stim_t st[$],
                            input logic [8:0] ex[$]);
        logic [8:0] e;
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL %s row%0d got=%b exp=%b",
                         name, i, observed(), e);
            end
            @(negedge CLK);
        end
        checks++;
        if (stall_cycles !== stall_m || flush_events !== flush_m) begin
            failures++;
            $display("FAIL %s_counters got=%h/%h exp=%h/%h", name,
                     stall_cycles, flush_events, stall_m, flush_m);
        end
    endtask

    task automatic test_dwait();
        stim_t st[$];
        logic [8:0] ex[$];
        st = '{mk(1,0,1,0,0,0,0,0,0,0,0), mk(1,0,1,0,0,0,0,0,0,0,0),
               mk(1,0,1,0,1,1,0,0,0,0,0), mk(1,1,1,0,0,0,0,0,0,0,0),
               mk(1,0,0,0,0,0,0,0,0,0,0), mk(1,1,0,1,0,0,0,0,0,0,0),
               mk(1,0,0,0,0,0,0,0,0,0,0)};
        ex = '{{1'b0, FRZ}, {1'b0, FRZ}, {1'b0, FRZ}, {1'b0, NORM},
               {1'b0, NORM}, {1'b0, NORM}, {1'b0, NORM}};
        run_rows("dwait", st, ex);
        checks++;
        if (stall_cycles !== 32'd3) begin
            failures++;
            $display("FAIL dwait_stall3 got=%0d exp=3", stall_cycles);
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [8:0] ex[$];
        st = '{mk(1,0,0,0,0,0,1,5,5,0,0), mk(1,0,0,0,0,0,0,0,0,0,0),
               mk(1,0,0,0,0,0,1,0,0,0,0), mk(1,0,0,0,0,0,1,7,1,7,0),
               mk(1,0,0,0,0,0,1,7,1,7,1), mk(0,0,0,0,0,0,1,9,9,0,0),
               mk(0,0,0,0,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,5,5,0,0),
               mk(1,0,0,0,0,0,0,0,0,0,0)};
        ex = '{{1'b0, LU}, {1'b0, NORM}, {1'b0, NORM}, {1'b0, NORM},
               {1'b0, LU}, {1'b0, LU}, {1'b0, IMS}, {1'b0, NORM},
               {1'b0, NORM}};
        run_rows("load_use", st, ex);
    endtask

    task automatic test_branch();
        stim_t st[$];
        logic [8:0] ex[$];
        logic [31:0] s0;
        s0 = stall_cycles;
        st = '{mk(0,0,0,0,1,0,0,0,0,0,0), mk(1,0,0,0,1,0,1,3,3,0,0),
               mk(1,0,1,0,0,0,0,0,0,0,0), mk(1,1,1,0,1,0,0,0,0,0,0),
               mk(1,0,0,1,1,0,0,0,0,0,0), mk(1,1,0,1,0,0,0,0,0,0,0),
               mk(1,0,0,0,0,0,0,0,0,0,0)};
        ex = '{{1'b0, BRN}, {1'b0, BRN}, {1'b0, FRZ}, {1'b0, BRN},
               {1'b0, FRZ}, {1'b0, NORM}, {1'b0, NORM}};
        run_rows("branch", st, ex);
        checks++;
        if (flush_events !== 16'd3 || stall_cycles !== s0 + 32'd2) begin
            failures++;
            $display("FAIL branch_totals got=%0d/%0d exp=3/%0d",
                     flush_events, stall_cycles, s0 + 32'd2);
        end
    endtask

    task automatic test_halt();
        stim_t st[$];
        logic [8:0] ex[$];
        st = '{mk(1,0,0,0,1,1,0,0,0,0,0), mk(1,0,0,0,0,0,0,0,0,0,0),
               mk(0,0,0,0,1,0,0,0,0,0,0), mk(1,1,1,0,0,0,0,0,0,0,0),
               mk(1,0,0,0,0,1,1,4,4,0,0), mk(1,0,0,0,0,0,0,0,0,0,0)};
        ex = '{{1'b0, HLT}, {1'b0, HLT}, {1'b1, FRZ}, {1'b1, FRZ},
               {1'b1, FRZ}, {1'b1, FRZ}};
        run_rows("halt", st, ex);
        do_reset();
        checks++;
        if (halt !== 1'b0 || stall_cycles !== 32'd0 ||
            flush_events !== 16'd0) begin
            failures++;
            $display("FAIL halt_reset got=%b/%h/%h exp=0/0/0",
                     halt, stall_cycles, flush_events);
        end
        st = '{mk(1,0,0,0,0,0,0,0,0,0,0)};
        ex = '{{1'b0, NORM}};
        run_rows("post_halt", st, ex);
    endtask

    task automatic test_reset_mid();
        stim_t st[$];
        logic [8:0] ex[$];
        st = '{mk(1,0,1,0,0,0,0,0,0,0,0), mk(1,0,1,0,0,0,0,0,0,0,0)};
        ex = '{{1'b0, FRZ}, {1'b0, FRZ}};
        run_rows("pre_rst_dwait", st, ex);
        do_reset();
        st = '{mk(1,0,0,0,0,0,0,0,0,0,0), mk(1,0,0,0,0,1,0,0,0,0,0),
               mk(1,0,0,0,0,0,0,0,0,0,0)};
        ex = '{{1'b0, NORM}, {1'b0, HLT}, {1'b0, HLT}};
        run_rows("rst_dwait", st, ex);
        do_reset();
        st = '{mk(1,0,0,0,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0,0,0,0)};
        ex = '{{1'b0, NORM}, {1'b0, NORM}};
        run_rows("rst_halting", st, ex);
    endtask

    task automatic test_stall_sat();
        logic [8:0] e;
        force dut.stall_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_q;
        stall_m = 32'hFFFF_FFFD;
        for (int i = 0; i < 4; i++) begin
            apply(mk(0,0,0,0,0,0,0,0,0,0,0), {1'b0, IMS});
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL stall_sat_ctl row%0d got=%b exp=%b",
                         i, observed(), e);
            end
            @(negedge CLK);
            checks++;
            if (stall_cycles !== stall_m) begin
                failures++;
                $display("FAIL stall_sat row%0d got=%h exp=%h",
                         i, stall_cycles, stall_m);
            end
        end
    endtask

    task automatic test_flush_sat();
        logic [8:0] e;
        int bad;
        bad = 0;
        for (int i = 0; i < 65538; i++) begin
            apply(mk(1,0,0,0,1,0,0,0,0,0,0), {1'b0, BRN});
            #2;
            e = exp_q.pop_front();
            if (observed() !== e) bad++;
            @(negedge CLK);
            if (i == 65534) begin
                checks++;
                if (flush_events !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL flush_reach got=%h exp=ffff",
                             flush_events);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL flush_sat_ctl got=%0d bad rows exp=0", bad);
        end
        checks++;
        if (flush_events !== flush_m || stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL flush_sat got=%h/%h exp=%h/0",
                     flush_events, stall_cycles, flush_m);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        stall_m  = 32'd0;
        flush_m  = 16'd0;
        nRST     = 1'b0;
        ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0;
        mem_branch_taken = 0; mem_halt = 0; ex_dREN = 0;
        ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        test_reset();
        test_normal();
        test_dwait();
        test_load_use();
        test_branch();
        test_halt();
        test_reset_mid();
        do_reset();
        test_stall_sat();
        do_reset();
        test_flush_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
